// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch mode sequencer.
package sw_pkg;

  localparam int TIME_W = 16;
  // 9:59.9 is the largest value the M:SS.d counter can show.
  localparam logic [TIME_W-1:0] TIME_MAX  = 16'h9599;
  localparam logic [TIME_W-1:0] TIME_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SPLIT  = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_RECALL = 3'd4
  } state_t;

endpackage

// File: rtl/lap_bank.sv
// Lap register file: one write port at wr_ptr and one async read port.
// Owns the lap count, the full flag and the index of the most recent write.
// Writes that arrive while the bank is full are discarded.
module lap_bank
  import sw_pkg::*;
#(
  parameter int LAP_DEPTH = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [TIME_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TIME_W-1:0] rd_data,
  output logic [IDX_W:0]    lap_cnt,
  output logic              lap_full,
  output logic [IDX_W-1:0]  last_idx
);

  logic [TIME_W-1:0] mem [LAP_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic              do_write;

  assign lap_full = (lap_cnt == (IDX_W+1)'(LAP_DEPTH));
  assign do_write = we && !lap_full && !clr;
  assign rd_data  = mem[rd_idx];

  // Storage: no reset needed, only entries below lap_cnt are ever shown.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer, count and last-written index; clr empties the bank.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr   <= '0;
      lap_cnt  <= '0;
      last_idx <= '0;
    end else if (do_write) begin
      wr_ptr   <= wr_ptr + 1'b1;
      lap_cnt  <= lap_cnt + 1'b1;
      last_idx <= wr_ptr;
    end
  end

endmodule

// File: rtl/stopwatch_seq_ctrl.sv
// Mode sequencer for the M:SS.d stopwatch: run/pause/split/recall FSM,
// split hold timer and display source mux. Event priority in one cycle is
// clr_p > start_p > max-stop > lap_p, among the events that are legal in
// the current state; the losing events are dropped.
module stopwatch_seq_ctrl
  import sw_pkg::*;
#(
  parameter int LAP_DEPTH  = 4,
  parameter int IDX_W      = 2,
  parameter int HOLD_TICKS = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start_p,
  input  logic              lap_p,
  input  logic              clr_p,
  input  logic [TIME_W-1:0] time_in,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic [TIME_W-1:0] disp_time,
  output logic [IDX_W-1:0]  lap_idx,
  output logic [IDX_W:0]    lap_cnt,
  output logic              lap_full,
  output logic              running,
  output logic [2:0]        dbg_state
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [IDX_W-1:0]  rd_idx, rd_n;
  logic [TIME_W-1:0] frozen, frozen_n;
  logic              lap_we, lap_clr;
  logic [TIME_W-1:0] lap_rd_data;
  logic [IDX_W-1:0]  last_idx;
  logic              at_max, max_stop;

  assign at_max   = (time_in == TIME_MAX);
  assign max_stop = at_max && tick;

  lap_bank #(
    .LAP_DEPTH (LAP_DEPTH),
    .IDX_W     (IDX_W)
  ) u_lap_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (lap_we),
    .clr      (lap_clr),
    .wr_data  (time_in),
    .rd_idx   (rd_idx),
    .rd_data  (lap_rd_data),
    .lap_cnt  (lap_cnt),
    .lap_full (lap_full),
    .last_idx (last_idx)
  );

  // State, hold timer, recall index and frozen split registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      rd_idx   <= '0;
      frozen   <= TIME_ZERO;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rd_idx   <= rd_n;
      frozen   <= frozen_n;
    end
  end

  // Next-state logic with per-state event priority.
  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    rd_n     = rd_idx;
    frozen_n = frozen;
    lap_we   = 1'b0;
    lap_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_p) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (start_p || max_stop) begin
          state_n = ST_PAUSE;
        end else if (lap_p) begin
          state_n  = ST_SPLIT;
          frozen_n = time_in;
          lap_we   = 1'b1;
          hold_n   = HOLD_W'(HOLD_TICKS);
        end
      end
      ST_SPLIT: begin
        if (start_p || max_stop) begin
          state_n  = ST_PAUSE;
          frozen_n = TIME_ZERO;
          hold_n   = '0;
        end else if (lap_p) begin
          frozen_n = time_in;
          lap_we   = 1'b1;
          hold_n   = HOLD_W'(HOLD_TICKS);
        end else if (tick) begin
          // The tick that takes the timer to zero also releases the split.
          if (hold_cnt <= HOLD_W'(1)) begin
            state_n = ST_RUN;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (clr_p) begin
          state_n = ST_IDLE;
          lap_clr = 1'b1;
        end else if (start_p && !at_max) begin
          state_n = ST_RUN;
        end else if (lap_p && (lap_cnt != '0)) begin
          state_n = ST_RECALL;
          rd_n    = '0;
        end
      end
      ST_RECALL: begin
        if (clr_p) begin
          state_n = ST_IDLE;
          lap_clr = 1'b1;
          rd_n    = '0;
        end else if (start_p) begin
          state_n = ST_RUN;
          rd_n    = '0;
        end else if (lap_p) begin
          if ({1'b0, rd_idx} == lap_cnt - 1'b1) begin
            state_n = ST_PAUSE;
            rd_n    = '0;
          end else begin
            rd_n = rd_idx + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; cnt_en drops as soon as 9:59.9 shows.
  always_comb begin
    running   = (state == ST_RUN) || (state == ST_SPLIT);
    cnt_en    = running && !at_max;
    cnt_clr   = (state == ST_IDLE);
    lap_idx   = (state == ST_RECALL) ? rd_idx : last_idx;
    dbg_state = state;
    case (state)
      ST_SPLIT:  disp_time = frozen;
      ST_RECALL: disp_time = lap_rd_data;
      default:   disp_time = time_in;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// Directed bench for stopwatch_seq_ctrl. A small BCD counter model drives
// time_in from tick, cnt_en and cnt_clr the way the real counter would.
module tb_stopwatch_seq_ctrl;
  import sw_pkg::*;

  logic        clk, rst, tick, start_p, lap_p, clr_p;
  logic [15:0] time_in;
  logic        cnt_en, cnt_clr, lap_full, running;
  logic [15:0] disp_time;
  logic [1:0]  lap_idx;
  logic [2:0]  lap_cnt;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int fail_cnt  = 0;

  stopwatch_seq_ctrl #(.LAP_DEPTH(4), .IDX_W(2), .HOLD_TICKS(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start_p   (start_p),
    .lap_p     (lap_p),
    .clr_p     (clr_p),
    .time_in   (time_in),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_time (disp_time),
    .lap_idx   (lap_idx),
    .lap_cnt   (lap_cnt),
    .lap_full  (lap_full),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd5) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = r[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given pulses; time_in follows the counter model.
  task automatic cycle(input logic s, input logic l, input logic c, input logic t);
    logic adv, clr_now;
    start_p = s; lap_p = l; clr_p = c; tick = t;
    #2;
    adv     = t && cnt_en;
    clr_now = cnt_clr;
    @(posedge clk);
    #1;
    if (clr_now) time_in = 16'h0000;
    else if (adv) time_in = bcd_inc(time_in);
    start_p = 1'b0; lap_p = 1'b0; clr_p = 1'b0; tick = 1'b0;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; start_p = 1'b0; lap_p = 1'b0; clr_p = 1'b0; tick = 1'b0;
    time_in = 16'h0000;
    @(posedge clk); @(posedge clk);
    #1; rst = 1'b0; #1;
  endtask

  typedef struct {
    logic        s, l, c, t;
    logic        en, clr, run;
    logic [2:0]  cnt;
    logic [15:0] disp;
    state_t      st;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Table: {start, lap, clr, tick, cnt_en, cnt_clr, running, lap_cnt, disp, state}
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd0, 16'h0000, ST_IDLE};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 3'd0, 16'h0000, ST_IDLE};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 3'd0, 16'h0000, ST_RUN};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1, 3'd0, 16'h0001, ST_RUN};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1, 3'd0, 16'h0002, ST_RUN};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1, 3'd0, 16'h0002, ST_RUN};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1, 3'd1, 16'h0002, ST_SPLIT};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1, 3'd1, 16'h0002, ST_SPLIT};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 16'h0003, ST_PAUSE};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'd1, 16'h0003, ST_PAUSE};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 3'd1, 16'h0003, ST_RUN};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd1, 16'h0003, ST_PAUSE};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 16'h0002, ST_RECALL};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 16'h0003, ST_PAUSE};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 3'd0, 16'h0003, ST_IDLE};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 3'd0, 16'h0000, ST_IDLE};

    // Reset state
    do_reset();
    chk("rst cnt_en",  cnt_en, 0);
    chk("rst cnt_clr", cnt_clr, 1);
    chk("rst disp",    disp_time, 16'h0000);
    chk("rst lap_idx", lap_idx, 0);
    chk("rst lap_cnt", lap_cnt, 0);
    chk("rst running", running, 0);
    chk("rst state",   dbg_state, ST_IDLE);

    // Table-driven sequence
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].s, vecs[i].l, vecs[i].c, vecs[i].t);
      chk($sformatf("vec%0d cnt_en", i),  cnt_en,    vecs[i].en);
      chk($sformatf("vec%0d cnt_clr", i), cnt_clr,   vecs[i].clr);
      chk($sformatf("vec%0d running", i), running,   vecs[i].run);
      chk($sformatf("vec%0d lap_cnt", i), lap_cnt,   vecs[i].cnt);
      chk($sformatf("vec%0d disp", i),    disp_time, vecs[i].disp);
      chk($sformatf("vec%0d state", i),   dbg_state, vecs[i].st);
    end

    // Basic run/stop
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(25);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("runstop state",  dbg_state, ST_PAUSE);
    chk("runstop cnt_en", cnt_en, 0);
    chk("runstop disp",   disp_time, 16'h0025);

    // Split hold for 30 ticks
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(12);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("split lap_cnt", lap_cnt, 1);
    chk("split lap_idx", lap_idx, 0);
    for (int k = 1; k < 30; k++) begin
      ticks(1);
      chk($sformatf("split hold%0d disp", k), disp_time, 16'h0012);
    end
    ticks(1);
    chk("split release state", dbg_state, ST_RUN);
    chk("split release disp",  disp_time, 16'h0042);
    chk("split release cnt",   lap_cnt, 1);

    // Lap overflow: five laps into a four-deep bank
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ticks(1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf lap_cnt",  lap_cnt, 4);
    chk("ovf lap_full", lap_full, 1);
    chk("ovf lap_idx",  lap_idx, 3);
    chk("ovf state",    dbg_state, ST_SPLIT);
    chk("ovf disp",     disp_time, 16'h0005);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf pause disp", disp_time, 16'h0005);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_t;
      exp_t = 16'(k + 1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("ovf recall%0d disp", k), disp_time, exp_t);
      chk($sformatf("ovf recall%0d idx", k),  lap_idx, k);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf wrap state", dbg_state, ST_PAUSE);

    // Recall wrap with three laps
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10); cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10); cycle(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10); cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rcl pause disp", disp_time, 16'h0030);
    chk("rcl lap_cnt",    lap_cnt, 3);
    chk("rcl last idx",   lap_idx, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rcl0 state", dbg_state, ST_RECALL);
    chk("rcl0 disp",  disp_time, 16'h0010);
    chk("rcl0 idx",   lap_idx, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rcl1 disp",  disp_time, 16'h0020);
    chk("rcl1 idx",   lap_idx, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rcl2 disp",  disp_time, 16'h0030);
    chk("rcl2 idx",   lap_idx, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rcl wrap state", dbg_state, ST_PAUSE);
    chk("rcl wrap disp",  disp_time, 16'h0030);

    // Max stop at 9:59.9, with a lap in the same cycle losing to it
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    time_in = 16'h9598;
    #1;
    ticks(1);
    chk("max run state",  dbg_state, ST_RUN);
    chk("max run cnt_en", cnt_en, 0);
    chk("max run disp",   disp_time, 16'h9599);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("max stop state", dbg_state, ST_PAUSE);
    chk("max stop cnt",   lap_cnt, 0);
    chk("max stop disp",  disp_time, 16'h9599);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("max start ignored", dbg_state, ST_PAUSE);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("max lap ignored", dbg_state, ST_PAUSE);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("max clr state",   dbg_state, ST_IDLE);
    chk("max clr cnt_clr", cnt_clr, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("max cleared disp", disp_time, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
